// File: rtl/tinyqv_slice_serdes.sv
// Slice serialiser/deserialiser: IN_CH parallel words out LSB slice first, result slices back in.
// Optional TINYQV_SERDES_STALL_EN adds a stall input that freezes the SHIFT pass.
module tinyqv_slice_serdes #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned SLICE_W = 4,
  parameter int unsigned IN_CH   = 2,
  localparam int unsigned N      = WORD_W / SLICE_W,
  localparam int unsigned CW     = $clog2(N)
) (
  input  logic                       clk,
  input  logic                       rstn,
`ifdef TINYQV_SERDES_STALL_EN
  input  logic                       stall,
`endif
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_CH*WORD_W-1:0]    in_data,
  output logic [IN_CH*SLICE_W-1:0]   ser_slice,
  output logic                       ser_valid,
  output logic [CW-1:0]              ser_idx,
  output logic                       ser_first,
  output logic                       ser_last,
  input  logic [SLICE_W-1:0]         res_slice,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W-1:0]          out_word
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [CW-1:0]           idx_q, idx_d;
  logic [IN_CH*WORD_W-1:0] word_q, word_d;
  logic [WORD_W-1:0]       out_word_q, out_word_d;
  logic                    stall_w;
  logic                    idx_at_last;

`ifdef TINYQV_SERDES_STALL_EN
  assign stall_w = stall;
`else
  assign stall_w = 1'b0;
`endif

  assign idx_at_last = (idx_q == CW'(N - 1));

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StIdle:  in_ready = 1'b1;
      StDone:  in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    word_d     = word_q;
    out_word_d = out_word_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          word_d  = in_data;
          idx_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (!stall_w) begin
          out_word_d[int'(idx_q)*SLICE_W +: SLICE_W] = res_slice;
          if (idx_at_last) begin
            idx_d   = '0;
            state_d = StDone;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDone: begin
        if (out_ready) begin
          if (in_valid) begin
            word_d  = in_data;
            idx_d   = '0;
            state_d = StShift;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      word_q     <= '0;
      out_word_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      word_q     <= word_d;
      out_word_q <= out_word_d;
    end
  end

  // idx is 0 outside SHIFT, so each channel shows its idx-0 slice there
  for (genvar c = 0; c < IN_CH; c++) begin : g_ch
    assign ser_slice[c*SLICE_W +: SLICE_W] =
        word_q[c*WORD_W + int'(idx_q)*SLICE_W +: SLICE_W];
  end

  assign ser_valid = (state_q == StShift) && !stall_w;
  assign ser_idx   = idx_q;
  assign ser_first = ser_valid && (idx_q == '0);
  assign ser_last  = ser_valid && idx_at_last;
  assign out_valid = (state_q == StDone);
  assign out_word  = out_word_q;

endmodule

// File: doc/tinyqv_slice_serdes.md
Name: tinyqv_slice_serdes

Overview:
- Parametrised multi-channel slice serialiser/deserialiser for driving the nibble-serial tinyqv datapath from parallel words.
- Accepts IN_CH parallel words on a valid/ready handshake and presents them one SLICE_W slice per cycle, LSB slice first, together with the slice index.
- Collects one result slice per cycle back into a WORD_W word, presented on a valid/ready output.
- Used in bench harnesses and in the peripheral/bus side wherever a parallel word must cross into the slice-serial domain.

Parameters:
- WORD_W, 32, word width in bits; must be a multiple of SLICE_W.
- SLICE_W, 4, bits transferred per cycle.
- IN_CH, 2, number of parallel input words serialised in lockstep.
- N (derived, localparam), WORD_W/SLICE_W, slices per word; must be >= 2.
- CW (derived, localparam), $clog2(N), slice index width.

Ports:
- clk  input  1  clock.
- rstn  input  1  synchronous, active-low reset.
- in_valid  input  1  in_data valid.
- in_ready  output  1  block can accept in_data this cycle.
- in_data  input  IN_CH*WORD_W  channel c occupies bits [c*WORD_W +: WORD_W].
- ser_slice  output  IN_CH*SLICE_W  current slice of each channel; channel c occupies bits [c*SLICE_W +: SLICE_W].
- ser_valid  output  1  ser_slice/ser_idx meaningful this cycle.
- ser_idx  output  CW  slice index 0..N-1.
- ser_first  output  1  ser_valid && ser_idx==0.
- ser_last  output  1  ser_valid && ser_idx==N-1.
- res_slice  input  SLICE_W  result slice for the current ser_idx; sampled when ser_valid (and not stalled).
- out_valid  output  1  out_word holds a complete result.
- out_ready  input  1  consumer takes out_word.
- out_word  output  WORD_W  assembled result; slice i at [i*SLICE_W +: SLICE_W].

Behaviour:
- States: IDLE, SHIFT, DONE.
- Reset (rstn low at posedge): state IDLE, idx 0, ser_valid 0, out_valid 0, out_word 0, and the internal input word register 0. ser_slice therefore reads 0.
- Reset mid-SHIFT or in DONE abandons the transfer; no partial out_valid is produced.
- in_ready is combinational: 1 in IDLE; out_ready in DONE; 0 in SHIFT.
- IDLE: on in_valid && in_ready, latch in_data, set idx=0, go to SHIFT.
- SHIFT:
  - ser_valid=1.
  - ser_slice channel c = latched word c [idx*SLICE_W +: SLICE_W].
  - Each cycle, res_slice is written into out_word[idx*SLICE_W +: SLICE_W] and idx increments.
  - At idx==N-1 the write occurs, idx wraps to 0, state goes to DONE and out_valid is set.
- Latency: accept at cycle T; slices at T+1..T+N; out_valid first high at T+N+1.
- DONE:
  - out_valid=1 and out_word is stable until out_ready.
  - out_ready && !in_valid: out_valid cleared, go to IDLE.
  - out_ready && in_valid (simultaneous): out_valid cleared, new data latched, go to SHIFT. Back-to-back throughput is one word per N+1 cycles.
- in_valid in SHIFT is ignored (in_ready=0); the producer must hold it.
- out_word slices not yet written in the current pass retain their previous values. Consumers use out_word only when out_valid=1.
- ser_slice is combinational from the registers and holds its idx-0 value outside SHIFT.

Optional Feature:
- Macro: TINYQV_SERDES_STALL_EN.
- With the macro defined:
  - Adds input port stall (1 bit).
  - While stall=1 in SHIFT: idx, out_word and state are frozen, ser_valid=0, and res_slice is ignored.
  - ser_slice holds the current slice.
  - stall is ignored in IDLE and DONE.
  - Latency becomes N+1 plus the number of stalled SHIFT cycles.
- Without the macro: the port is absent and behaviour is as if stall=0.

Test Plan (WORD_W=32, SLICE_W=4, IN_CH=2, N=8):
- Reset then idle with in_valid=0 -> in_ready=1, ser_valid=0, out_valid=0, out_word=0x00000000 indefinitely.
- in_data={ch1=0xDEADBEEF, ch0=0x12345678}, res_slice driven equal to ch0's ser_slice -> ch0 slices 8,7,6,5,4,3,2,1 and ch1 slices F,E,E,B,D,A,E,D at idx 0..7. ser_first at idx 0, ser_last at idx 7. out_valid at T+9 with out_word=0x12345678.
- res_slice = (ch0 slice + ch1 slice) mod 16 for 0x11111111 and 0x22222222 -> out_word=0x33333333.
- Hold out_ready=0 for 5 cycles in DONE -> out_word stable, in_ready=0. Then out_ready=1 with in_valid=1 (0xCAFEF00D) -> same-cycle handoff, next out_valid exactly 9 cycles later.
- Assert rstn=0 at idx 4 of SHIFT -> next cycle state IDLE, ser_valid=0, out_valid=0, out_word=0.
- With TINYQV_SERDES_STALL_EN: stall=1 for 3 cycles at idx 2 -> ser_idx stays 2, ser_valid=0, out_valid delayed to T+12, out_word is still correct.
